// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-key conditioning path.
package key_pkg;

  localparam int KEY_DEBOUNCE_50MHZ = 1_000_000;

  // Gray-ordered so that every legal transition flips a single state bit.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } key_state_e;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pins, reset to a selectable idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // NOTE: non-blocking assignments make s2 take the old s1, giving a real two-stage shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Push-key conditioner: synchronise, normalise polarity, debounce, and emit
// a clean level with one-cycle press/release strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             press_q;
  logic             release_q;
  logic             pin_sync;
  logic             key_pressed;

  // Idle level preload keeps a released key from looking like an edge after reset.
  sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (in_i),
    .q_o (pin_sync)
  );

  assign key_pressed = pin_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_pressed) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!key_pressed) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_pressed) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out_o     = out_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Front-end conditioner for a raw mechanical push-key. Feeds the press-duration / LED-blink stage directly downstream.
- Synchronises the asynchronous pin and normalises its polarity.
- Debounces with a stability counter, then outputs a clean level plus one-cycle press and release strobes.
- The downstream stage times its press duration off `out` and must never see contact bounce.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range is 2 or more.
- ACTIVE_LOW, 1, set to 1 when the pin reads 0 while pressed; the raw level is inverted after synchronisation.

Ports:
- clk  input  1  system clock (single clock domain).
- rst  input  1  asynchronous, active-high reset.
- in  input  1  raw key pin, asynchronous to clk.
- out  output  1  debounced key level, 1 = pressed, registered.
- press  output  1  one-cycle strobe when out goes 0->1.
- release  output  1  one-cycle strobe when out goes 1->0.

Behaviour:
- Reset (async assert, sync deassert by system):
  - State = IDLE, counter = 0.
  - out = 0, press = 0, release = 0.
  - Both sync flops are loaded with the inactive pin level: 1 if ACTIVE_LOW, else 0. A held-released key therefore produces no spurious edge after reset.
- Synchroniser:
  - in -> s1 -> s2, two flops.
  - k = s2 XOR ACTIVE_LOW, so k = 1 means pressed.
- Counter:
  - Width is ceil(log2(DEBOUNCE_CYCLES)), minimum 1. It never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- FSM, all transitions on the rising edge of clk:
  - IDLE (out=0): if k=1, go to PRESS_WAIT with cnt=0. Otherwise stay.
  - PRESS_WAIT (out=0): checked in priority order:
    1. k=0 -> IDLE, cnt=0 (bounce rejected, no strobe).
    2. k=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, out<=1, press<=1.
    3. Otherwise cnt<=cnt+1.
  - PRESSED (out=1): if k=0, go to RELEASE_WAIT with cnt=0. Otherwise stay indefinitely; there is no timeout.
  - RELEASE_WAIT (out=1): checked in priority order:
    1. k=1 -> PRESSED, cnt=0 (bounce rejected, no strobe).
    2. k=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, out<=0, release<=1.
    3. Otherwise cnt<=cnt+1.
  - Unreachable encodings go to IDLE, cnt=0, all outputs 0.
- Strobes:
  - press and release default to 0 every cycle and are high for exactly one cycle.
  - press and release are never high together.
  - A press strobe is always followed by its matching release strobe before the next press.
- Latency:
  - Let edge 1 be the first clock edge at which s1 samples the new stable level.
  - out changes on edge DEBOUNCE_CYCLES+3: 2 sync edges, 1 wait-entry edge, then DEBOUNCE_CYCLES-1 count edges plus 1 accept edge.
  - The strobe is asserted in the same cycle that out changes.
- Boundaries:
  - A glitch shorter than DEBOUNCE_CYCLES+1 cycles of stable k never changes out.
  - A glitch of exactly one cycle on k during a wait state restarts the count from 0.
  - Reset asserted mid-wait or mid-strobe clears immediately. out drops to 0 even while the key is held, and a held key is re-qualified as a fresh press after reset release.

Decomposition:
- Shared package key_pkg holds:
  - The 2-bit state encoding: IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b11, RELEASE_WAIT=2'b10 (Gray order, one bit changes per transition).
  - Constant KEY_DEBOUNCE_50MHZ = 1_000_000.
- One sub-module: sync_2ff, a 2-flop synchroniser with a reset-value parameter, reusable for the other asynchronous pins.
- The FSM and counter stay in key_debounce.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, in idle high.
- Clean press: drive in=0 and hold it. out rises and press pulses for 1 cycle on edge 7 after the first sampling edge; release stays 0.
- Bounce reject: in=0 for 3 cycles, 1 for 1 cycle, then 0 held. out stays 0 until 7 edges after the final falling edge, and exactly one press strobe is issued.
- Short glitch: a 4-cycle low pulse on in with otherwise idle high. out stays 0 throughout and no strobes are issued.
- Release: after a press is accepted, drive in=1. out falls and release pulses for 1 cycle on edge 7; a 2-cycle low bounce during RELEASE_WAIT restarts the count.
- Reset mid-operation: assert rst while in PRESSED with in=0 held. out=0 immediately (asynchronously). After rst deasserts, press re-asserts on edge 7 with exactly one strobe.
- Polarity: with ACTIVE_LOW=0 and in idle 0, drive in=1. press strobe on edge 7, with no strobe in the cycles just after reset.
